// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming(7,4) SECDED widths, code positions and error kinds
package hamming_pkg;

   localparam int CODE_W = 7;
   localparam int DATA_W = 4;
   localparam int SYN_W  = 3;

   // Bit k of the code word is Hamming position k+1
   localparam int P1 = 0;
   localparam int P2 = 1;
   localparam int D0 = 2;
   localparam int P4 = 3;
   localparam int D1 = 4;
   localparam int D2 = 5;
   localparam int D3 = 6;

   typedef enum logic [1:0] {
      NONE    = 2'd0,
      CE_DATA = 2'd1,
      CE_PAR  = 2'd2,
      UE      = 2'd3
   } err_kind_t;

   function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
      return {code[D3], code[D2], code[D1], code[D0]};
   endfunction

endpackage

// File: rtl/hamming74_syndrome.sv
// rtl/hamming74_syndrome.sv - combinational syndrome, overall parity check, correction and data extraction
module hamming74_syndrome
   import hamming_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   input  logic              parity,
   output logic [DATA_W-1:0] data,
   output logic [SYN_W-1:0]  syndrome,
   output err_kind_t         kind
);

   logic              s1;
   logic              s2;
   logic              s4;
   logic              pe;
   logic [CODE_W-1:0] flip_mask;
   logic [CODE_W-1:0] fixed;

   assign s1 = code[P1] ^ code[D0] ^ code[D1] ^ code[D3];
   assign s2 = code[P2] ^ code[D0] ^ code[D2] ^ code[D3];
   assign s4 = code[P4] ^ code[D1] ^ code[D2] ^ code[D3];
   assign syndrome = {s4, s2, s1};
   assign pe = (^code) ^ parity;

   // A nonzero syndrome with even overall parity means two flips: leave the word untouched
   always_comb begin
      flip_mask = '0;
      kind      = NONE;
      if (syndrome != '0) begin
         if (pe) begin
            flip_mask = CODE_W'(1) << (syndrome - SYN_W'(1));
            kind      = CE_DATA;
         end else begin
            kind = UE;
         end
      end else if (pe) begin
         kind = CE_PAR;
      end
   end

   assign fixed = code ^ flip_mask;
   assign data  = extract_data(fixed);

endmodule

// File: rtl/hamming74_secded_decoder.sv
// rtl/hamming74_secded_decoder.sv - two-stage SECDED decoder with handshakes and saturating error counters; optional HAM_DEC_ERR_LOG_EN
module hamming74_secded_decoder
   import hamming_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [CODE_W-1:0] i_hamming_code,
   input  logic              i_parity,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_ce,
   output logic              o_ue,
   output logic [SYN_W-1:0]  o_syndrome,
   input  logic              i_cnt_clr,
   output logic [CNT_W-1:0]  o_ce_cnt,
   output logic [CNT_W-1:0]  o_ue_cnt
`ifdef HAM_DEC_ERR_LOG_EN
   ,
   output logic              o_log_valid,
   output logic [7:0]        o_log_code
`endif
);

   logic              s1_valid;
   logic [CODE_W-1:0] s1_code;
   logic              s1_parity;
   logic              s2_load;
   logic              out_hs;
   logic [DATA_W-1:0] dec_data;
   logic [SYN_W-1:0]  dec_syn;
   err_kind_t         dec_kind;

   assign s2_load = s1_valid && (!o_valid || i_ready);
   assign o_ready = !s1_valid || s2_load;
   assign out_hs  = o_valid && i_ready;

   // Stage 1 refills in the same cycle it drains, so o_ready alone decides the next valid
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid  <= 1'b0;
         s1_code   <= '0;
         s1_parity <= 1'b0;
      end else if (o_ready) begin
         s1_valid <= i_valid;
         if (i_valid) begin
            s1_code   <= i_hamming_code;
            s1_parity <= i_parity;
         end
      end
   end

   hamming74_syndrome u_syndrome (
      .code     (s1_code),
      .parity   (s1_parity),
      .data     (dec_data),
      .syndrome (dec_syn),
      .kind     (dec_kind)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid    <= 1'b0;
         o_data     <= '0;
         o_ce       <= 1'b0;
         o_ue       <= 1'b0;
         o_syndrome <= '0;
      end else if (s2_load) begin
         o_valid    <= 1'b1;
         o_data     <= dec_data;
         o_ce       <= (dec_kind == CE_DATA) || (dec_kind == CE_PAR);
         o_ue       <= (dec_kind == UE);
         o_syndrome <= dec_syn;
      end else if (out_hs) begin
         o_valid <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_ce_cnt <= '0;
         o_ue_cnt <= '0;
      end else if (i_cnt_clr) begin
         o_ce_cnt <= '0;
         o_ue_cnt <= '0;
      end else if (out_hs) begin
         if (o_ce && (o_ce_cnt != '1)) o_ce_cnt <= o_ce_cnt + CNT_W'(1);
         if (o_ue && (o_ue_cnt != '1)) o_ue_cnt <= o_ue_cnt + CNT_W'(1);
      end
   end

`ifdef HAM_DEC_ERR_LOG_EN
   logic [7:0] s2_raw;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s2_raw <= '0;
      end else if (s2_load) begin
         s2_raw <= {s1_parity, s1_code};
      end
   end

   // Only the first uncorrectable word after a clear is captured
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_log_valid <= 1'b0;
         o_log_code  <= '0;
      end else if (i_cnt_clr) begin
         o_log_valid <= 1'b0;
         o_log_code  <= '0;
      end else if (out_hs && o_ue && !o_log_valid) begin
         o_log_valid <= 1'b1;
         o_log_code  <= s2_raw;
      end
   end
`endif

endmodule

// File: tb/tb_hamming74_secded_decoder.sv
// tb/tb_hamming74_secded_decoder.sv - self-checking bench: directed cases plus randomized words against a nearest-codeword model
module tb_hamming74_secded_decoder;

   localparam int CW      = 2;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic [6:0]    code = '0;
   logic          i_parity = 1'b0;
   logic          o_valid;
   logic          i_ready = 1'b0;
   logic [3:0]    o_data;
   logic          o_ce;
   logic          o_ue;
   logic [2:0]    o_syn;
   logic          cnt_clr = 1'b0;
   logic [CW-1:0] ce_cnt;
   logic [CW-1:0] ue_cnt;

   always #5 clk = ~clk;

   hamming74_secded_decoder #(.CNT_W(CW)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_valid        (i_valid),
      .o_ready        (o_ready),
      .i_hamming_code (code),
      .i_parity       (i_parity),
      .o_valid        (o_valid),
      .i_ready        (i_ready),
      .o_data         (o_data),
      .o_ce           (o_ce),
      .o_ue           (o_ue),
      .o_syndrome     (o_syn),
      .i_cnt_clr      (cnt_clr),
      .o_ce_cnt       (ce_cnt),
      .o_ue_cnt       (ue_cnt)
   );

   int         total = 0;
   int         passed = 0;
   logic [8:0] exp_q[$];
   int         m_ce = 0;
   int         m_ue = 0;
   logic       obs_ready;
   logic       obs_valid;
   logic [8:0] obs_word;
   logic       hold_pending = 1'b0;
   logic [8:0] held;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // {parity, code} of the codeword carrying data d
   function automatic logic [7:0] enc(input logic [3:0] d);
      logic [6:0] c;
      c[0] = d[0] ^ d[1] ^ d[3];
      c[1] = d[0] ^ d[2] ^ d[3];
      c[2] = d[0];
      c[3] = d[1] ^ d[2] ^ d[3];
      c[4] = d[1];
      c[5] = d[2];
      c[6] = d[3];
      return {^c, c};
   endfunction

   // Nearest-codeword decode; result packed {data, ce, ue, syndrome}
   function automatic logic [8:0] ref_decode(input logic [7:0] w);
      int         syn = 0;
      logic [7:0] cw;
      for (int k = 0; k < 7; k++) if (w[k]) syn = syn ^ (k + 1);
      for (int d = 0; d < 16; d++) begin
         cw = enc(4'(d));
         if ($countones(cw ^ w) == 0) return {4'(d), 1'b0, 1'b0, 3'(syn)};
         if ($countones(cw ^ w) == 1) return {4'(d), 1'b1, 1'b0, 3'(syn)};
      end
      return {w[6], w[5], w[4], w[2], 1'b0, 1'b1, 3'(syn)};
   endfunction

   function automatic logic [7:0] rand_word(input int nflip);
      logic [7:0] w;
      int         a;
      int         b;
      w = enc(4'($urandom_range(0, 15)));
      a = $urandom_range(0, 7);
      b = (a + $urandom_range(1, 7)) % 8;
      if (nflip >= 1) w[a] = ~w[a];
      if (nflip >= 2) w[b] = ~w[b];
      return w;
   endfunction

   task automatic step(input logic v, input logic [7:0] w, input logic r, input logic clr);
      logic       hs;
      logic [8:0] e;
      hs = 1'b0;
      e  = '0;
      @(negedge clk);
      i_valid  = v;
      code     = w[6:0];
      i_parity = w[7];
      i_ready  = r;
      cnt_clr  = clr;
      #1;
      obs_ready = o_ready;
      obs_valid = o_valid;
      obs_word  = {o_data, o_ce, o_ue, o_syn};
      chk("ce_cnt", 32'(ce_cnt), 32'(m_ce));
      chk("ue_cnt", 32'(ue_cnt), 32'(m_ue));
      if (hold_pending) chk("hold", 32'({o_valid, obs_word}), 32'({1'b1, held}));
      if (o_valid && i_ready) begin
         chk("out_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            hs = 1'b1;
            chk("out_word", 32'(obs_word), 32'(e));
         end
      end
      hold_pending = o_valid && !i_ready;
      held         = obs_word;
      if (v && o_ready) exp_q.push_back(ref_decode(w));
      @(posedge clk);
      if (clr) begin
         m_ce = 0;
         m_ue = 0;
      end else if (hs) begin
         if (e[4] && m_ce < CNT_MAX) m_ce++;
         if (e[3] && m_ue < CNT_MAX) m_ue++;
      end
   endtask

   task automatic single(input string tag, input logic [7:0] w, input logic [8:0] exp);
      step(1'b1, w, 1'b1, 1'b0);
      chk({tag, "_ready"}, 32'(obs_ready), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk({tag, "_lat1"}, 32'(obs_valid), 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk({tag, "_lat2"}, 32'(obs_valid), 32'd1);
      chk(tag, 32'(obs_word), 32'(exp));
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      logic [7:0] bp[4];

      #2 rst_n = 1'b0;
      #2;
      chk("rst_outputs", 32'({o_valid, o_data, o_ce, o_ue, o_syn}), 32'd0);
      chk("rst_counters", 32'({ce_cnt, ue_cnt}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_ready", 32'(o_ready), 32'd1);

      single("clean", {1'b0, 7'h55}, {4'b1011, 1'b0, 1'b0, 3'd0});
      single("ce_data", {1'b0, 7'h45}, {4'b1011, 1'b1, 1'b0, 3'd5});
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("ce_cnt_1", 32'(ce_cnt), 32'd1);
      single("ce_par", {1'b1, 7'h55}, {4'b1011, 1'b1, 1'b0, 3'd0});
      single("ue", {1'b0, 7'h56}, {4'b1011, 1'b0, 1'b1, 3'd3});
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("ce_cnt_2", 32'(ce_cnt), 32'd2);
      chk("ue_cnt_1", 32'(ue_cnt), 32'd1);

      for (int i = 0; i < 4; i++) bp[i] = rand_word(i % 3);
      step(1'b1, bp[0], 1'b0, 1'b0);
      chk("bp_ready0", 32'(obs_ready), 32'd1);
      step(1'b1, bp[1], 1'b0, 1'b0);
      chk("bp_ready1", 32'(obs_ready), 32'd1);
      step(1'b1, bp[2], 1'b0, 1'b0);
      chk("bp_ready2", 32'(obs_ready), 32'd0);
      step(1'b1, bp[2], 1'b1, 1'b0);
      chk("bp_release", 32'(obs_ready), 32'd1);
      step(1'b1, bp[3], 1'b1, 1'b0);
      chk("bp_last", 32'(obs_ready), 32'd1);
      drain(3);
      chk("bp_empty", 32'(exp_q.size()), 32'd0);

      for (int i = 0; i < 6; i++) begin
         step(1'b1, rand_word($urandom_range(0, 2)), 1'b1, 1'b0);
         chk("full_rate", 32'(obs_ready), 32'd1);
      end
      drain(3);

      step(1'b0, 8'h00, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, rand_word(1), 1'b1, 1'b0);
      drain(3);
      chk("ce_sat", 32'(ce_cnt), 32'd3);

      step(1'b1, rand_word(1), 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("clr_hs_valid", 32'(obs_valid), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("clr_priority", 32'(ce_cnt), 32'd0);

      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 9) < 7, rand_word($urandom_range(0, 2)),
              $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
      drain(4);
      chk("rand_empty", 32'(exp_q.size()), 32'd0);

      for (int i = 0; i < 3; i++) step(1'b1, rand_word(i + 1), 1'b1, 1'b0);
      step(1'b1, rand_word(0), 1'b0, 1'b0);
      step(1'b1, rand_word(1), 1'b0, 1'b0);
      #2;
      chk("pre_rst_full", 32'(o_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(o_valid), 32'd0);
      chk("async_rst_ready", 32'(o_ready), 32'd1);
      chk("async_rst_cnt", 32'({ce_cnt, ue_cnt}), 32'd0);
      exp_q.delete();
      m_ce = 0;
      m_ue = 0;
      hold_pending = 1'b0;
      @(negedge clk);
      i_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         chk("post_rst_quiet", 32'(obs_valid), 32'd0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
